// File: rtl/hazard_trk_if.sv
// hazard_trk_if
//   Bundle between the hazard unit / decode stage and hazard_tracker.
//   D-stage register tags, decode controls, the E-stage condition result and
//   the hazard-unit stall/flush controls flow into the tracker. Address
//   matches and qualified write/PC-write controls flow back out.
//   master : hazard unit / decode side (drives tags and controls)
//   slave  : hazard_tracker (consumes tags, produces matches)
interface hazard_trk_if #(
  parameter int REG_AW = 4
);
  logic              FetchValidF;
  logic [REG_AW-1:0] RA1D;
  logic [REG_AW-1:0] RA2D;
  logic [REG_AW-1:0] WA3D;
  logic              RegWriteD;
  logic              MemtoRegD;
  logic              BranchD;
  logic              CondExE;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;

  logic              Match_1E_M;
  logic              Match_1E_W;
  logic              Match_2E_M;
  logic              Match_2E_W;
  logic              Match_12D_E;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              PCWrPendingF;
  logic              PCSrcW;

  modport master (
    output FetchValidF, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchD,
           CondExE, StallD, FlushD, FlushE,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
           RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW
  );

  modport slave (
    input  FetchValidF, RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, BranchD,
           CondExE, StallD, FlushD, FlushE,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
           RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW
  );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker
//   Tag pipeline that runs beside the datapath pipeline registers. It carries
//   register addresses, write enables, load and PC-write flags down the
//   D/E/M/W stages, honours StallD/FlushD/FlushE, and produces the address
//   matches and qualified controls consumed by the hazard unit. No data
//   values are held, only tags and valid bits.
// Ports
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous active-low reset (0 = reset)
//   hz     : hazard_trk_if.slave bundle (tags/controls in, matches out)
//   StallCount, FlushCount : saturating perf counters, present only when the
//            HAZARD_TRK_PERF_EN macro is defined
// Build option
//   HAZARD_TRK_PERF_EN : adds the StallCount/FlushCount counters and ports.
module hazard_tracker #(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15
`ifdef HAZARD_TRK_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  hazard_trk_if.slave       hz
`ifdef HAZARD_TRK_PERF_EN
  , output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0]   FlushCount
`endif
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);

  // D stage
  logic              d_valid_q, d_valid_d;
  // E stage
  logic              e_valid_q, e_valid_d;
  logic [REG_AW-1:0] e_ra1_q, e_ra1_d;
  logic [REG_AW-1:0] e_ra2_q, e_ra2_d;
  logic [REG_AW-1:0] e_wa3_q, e_wa3_d;
  logic              e_reg_write_q, e_reg_write_d;
  logic              e_mem_to_reg_q, e_mem_to_reg_d;
  logic              e_pc_src_q, e_pc_src_d;
  // M stage
  logic [REG_AW-1:0] m_wa3_q, m_wa3_d;
  logic              m_reg_write_q, m_reg_write_d;
  logic              m_pc_src_q, m_pc_src_d;
  // W stage
  logic [REG_AW-1:0] w_wa3_q, w_wa3_d;
  logic              w_reg_write_q, w_reg_write_d;
  logic              w_pc_src_q, w_pc_src_d;

  // Decode instruction will write the PC, either as a branch or as an
  // ordinary register write that happens to target PC_REG.
  logic pc_src_dec;

  always_comb begin
    pc_src_dec = d_valid_q & (hz.BranchD | (hz.RegWriteD & (hz.WA3D == PC_ADDR)));

    // Flush beats stall when both arrive together.
    if (hz.FlushD)      d_valid_d = 1'b0;
    else if (hz.StallD) d_valid_d = d_valid_q;
    else                d_valid_d = hz.FetchValidF;

    // A FlushE bubble clears only the control bits; addresses keep their old
    // values, which is harmless because every match is gated by e_valid_q.
    e_ra1_d        = e_ra1_q;
    e_ra2_d        = e_ra2_q;
    e_wa3_d        = e_wa3_q;
    e_valid_d      = 1'b0;
    e_reg_write_d  = 1'b0;
    e_mem_to_reg_d = 1'b0;
    e_pc_src_d     = 1'b0;
    if (!hz.FlushE) begin
      e_valid_d      = d_valid_q;
      e_ra1_d        = hz.RA1D;
      e_ra2_d        = hz.RA2D;
      e_wa3_d        = hz.WA3D;
      e_reg_write_d  = hz.RegWriteD & d_valid_q;
      e_mem_to_reg_d = hz.MemtoRegD & d_valid_q;
      e_pc_src_d     = pc_src_dec;
    end

    // A failed condition in E cancels the write side effects downstream.
    m_wa3_d       = e_wa3_q;
    m_reg_write_d = e_reg_write_q & hz.CondExE;
    m_pc_src_d    = e_pc_src_q & hz.CondExE;

    w_wa3_d       = m_wa3_q;
    w_reg_write_d = m_reg_write_q;
    w_pc_src_d    = m_pc_src_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid_q      <= 1'b0;
      e_valid_q      <= 1'b0;
      e_ra1_q        <= '0;
      e_ra2_q        <= '0;
      e_wa3_q        <= '0;
      e_reg_write_q  <= 1'b0;
      e_mem_to_reg_q <= 1'b0;
      e_pc_src_q     <= 1'b0;
      m_wa3_q        <= '0;
      m_reg_write_q  <= 1'b0;
      m_pc_src_q     <= 1'b0;
      w_wa3_q        <= '0;
      w_reg_write_q  <= 1'b0;
      w_pc_src_q     <= 1'b0;
    end else begin
      d_valid_q      <= d_valid_d;
      e_valid_q      <= e_valid_d;
      e_ra1_q        <= e_ra1_d;
      e_ra2_q        <= e_ra2_d;
      e_wa3_q        <= e_wa3_d;
      e_reg_write_q  <= e_reg_write_d;
      e_mem_to_reg_q <= e_mem_to_reg_d;
      e_pc_src_q     <= e_pc_src_d;
      m_wa3_q        <= m_wa3_d;
      m_reg_write_q  <= m_reg_write_d;
      m_pc_src_q     <= m_pc_src_d;
      w_wa3_q        <= w_wa3_d;
      w_reg_write_q  <= w_reg_write_d;
      w_pc_src_q     <= w_pc_src_d;
    end
  end

  // Matches are raw address compares; RegWrite qualification is done by the
  // hazard unit using RegWriteM/RegWriteW.
  assign hz.Match_1E_M   = e_valid_q & (e_ra1_q == m_wa3_q);
  assign hz.Match_1E_W   = e_valid_q & (e_ra1_q == w_wa3_q);
  assign hz.Match_2E_M   = e_valid_q & (e_ra2_q == m_wa3_q);
  assign hz.Match_2E_W   = e_valid_q & (e_ra2_q == w_wa3_q);
  assign hz.Match_12D_E  = d_valid_q & e_valid_q &
                           ((hz.RA1D == e_wa3_q) | (hz.RA2D == e_wa3_q));
  assign hz.RegWriteM    = m_reg_write_q;
  assign hz.RegWriteW    = w_reg_write_q;
  assign hz.MemtoRegE    = e_mem_to_reg_q;
  assign hz.PCWrPendingF = pc_src_dec | e_pc_src_q | m_pc_src_q;
  assign hz.PCSrcW       = w_pc_src_q;

`ifdef HAZARD_TRK_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters stop at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallD && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((hz.FlushD || hz.FlushE) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker
//   Randomized stimulus against a reference model of in-flight instructions.
//   Each cycle the stimulus process computes the outputs the model predicts
//   and queues them; an independent monitor pops and compares on the falling
//   edge. A mid-run asynchronous reset is included.
module tb_hazard_tracker;

  localparam int AW    = 4;
  localparam int PCR   = 15;
  localparam int NCYC  = 3000;
  localparam int RST_AT = 1200;
`ifdef HAZARD_TRK_PERF_EN
  localparam int CNTW  = 16;
  localparam int CMAX  = (1 << CNTW) - 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_trk_if #(.REG_AW(AW)) hz ();

`ifdef HAZARD_TRK_PERF_EN
  logic [CNTW-1:0] stall_count, flush_count;
  hazard_tracker #(.REG_AW(AW), .PC_REG(PCR), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(rst_n), .hz(hz),
    .StallCount(stall_count), .FlushCount(flush_count));
`else
  hazard_tracker #(.REG_AW(AW), .PC_REG(PCR)) dut (
    .clk(clk), .reset(rst_n), .hz(hz));
`endif

  // One instruction as seen by the hazard logic.
  typedef struct {
    bit     v;
    int     ra1, ra2, wa3;
    bit     rw, ld, pcw;
  } instr_t;

  typedef struct {
    bit fv, rw, ld, br, cond, stall, fd, fe;
    int ra1, ra2, wa3;
  } stim_t;

  typedef struct {
    logic [9:0] outs;
    int         stall_cnt, flush_cnt;
    int         cyc;
  } exp_t;

  // Instructions in flight: index 1 = E, 2 = M, 3 = W. D is only a valid bit
  // since its addresses come straight from the inputs.
  instr_t pipe [1:3];
  bit     d_valid;
  int     m_stall_cnt, m_flush_cnt;
  stim_t  cur;
  exp_t   exp_q [$];
  int     errors = 0;
  int     checks = 0;
  int     cyc_no = 0;

  function automatic instr_t bubble_of(instr_t x);
    instr_t b = x;
    b.v = 0; b.rw = 0; b.ld = 0; b.pcw = 0;
    return b;
  endfunction

  function automatic bit dec_writes_pc();
    return d_valid && (cur.br || (cur.rw && cur.wa3 == PCR));
  endfunction

  task automatic model_clear();
    instr_t z = '{v:0, ra1:0, ra2:0, wa3:0, rw:0, ld:0, pcw:0};
    for (int i = 1; i <= 3; i++) pipe[i] = z;
    d_valid = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Advance every instruction one stage using the inputs held this cycle.
  task automatic model_step();
    instr_t from_d;
    if (!rst_n) return;
    if (cur.stall && m_stall_cnt < 65535) m_stall_cnt++;
    if ((cur.fd || cur.fe) && m_flush_cnt < 65535) m_flush_cnt++;
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    if (!cur.cond) begin
      pipe[2].rw  = 0;
      pipe[2].pcw = 0;
    end
    from_d.v   = d_valid;
    from_d.ra1 = cur.ra1;
    from_d.ra2 = cur.ra2;
    from_d.wa3 = cur.wa3;
    from_d.rw  = cur.rw && d_valid;
    from_d.ld  = cur.ld && d_valid;
    from_d.pcw = dec_writes_pc();
    pipe[1] = cur.fe ? bubble_of(pipe[1]) : from_d;
    if (cur.fd)          d_valid = 0;
    else if (!cur.stall) d_valid = cur.fv;
  endtask

  function automatic logic [9:0] model_outs();
    instr_t e = pipe[1], m = pipe[2], w = pipe[3];
    logic [9:0] o;
    o[9] = e.v && e.ra1 == m.wa3;
    o[8] = e.v && e.ra1 == w.wa3;
    o[7] = e.v && e.ra2 == m.wa3;
    o[6] = e.v && e.ra2 == w.wa3;
    o[5] = d_valid && e.v && (cur.ra1 == e.wa3 || cur.ra2 == e.wa3);
    o[4] = m.rw;
    o[3] = w.rw;
    o[2] = e.ld;
    o[1] = dec_writes_pc() || e.pcw || m.pcw;
    o[0] = w.pcw;
    return o;
  endfunction

  function automatic int pick_reg();
    int r = $urandom_range(0, 9);
    return (r > 3) ? (r % 4) : ((r == 3) ? PCR : r);
  endfunction

  task automatic apply_stim();
    hz.FetchValidF = cur.fv;
    hz.RA1D        = AW'(cur.ra1);
    hz.RA2D        = AW'(cur.ra2);
    hz.WA3D        = AW'(cur.wa3);
    hz.RegWriteD   = cur.rw;
    hz.MemtoRegD   = cur.ld;
    hz.BranchD     = cur.br;
    hz.CondExE     = cur.cond;
    hz.StallD      = cur.stall;
    hz.FlushD      = cur.fd;
    hz.FlushE      = cur.fe;
  endtask

  task automatic random_stim(bit force_stall);
    cur.fv    = ($urandom_range(0, 9) < 8);
    cur.ra1   = pick_reg();
    cur.ra2   = pick_reg();
    cur.wa3   = pick_reg();
    cur.rw    = ($urandom_range(0, 9) < 7);
    cur.ld    = ($urandom_range(0, 9) < 3);
    cur.br    = ($urandom_range(0, 9) < 1);
    cur.cond  = ($urandom_range(0, 9) < 8);
    cur.stall = force_stall || ($urandom_range(0, 9) < 2);
    cur.fd    = ($urandom_range(0, 9) < 1);
    // The hazard unit normally pairs a D stall with an E bubble.
    cur.fe    = cur.stall ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
  endtask

  task automatic push_expect();
    exp_t x;
    x.outs      = model_outs();
    x.stall_cnt = m_stall_cnt;
    x.flush_cnt = m_flush_cnt;
    x.cyc       = cyc_no;
    exp_q.push_back(x);
  endtask

  task automatic one_cycle(bit force_stall);
    @(posedge clk);
    model_step();
    #1;
    cyc_no++;
    random_stim(force_stall);
    apply_stim();
    push_expect();
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t x;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        act = {hz.Match_1E_M, hz.Match_1E_W, hz.Match_2E_M, hz.Match_2E_W,
               hz.Match_12D_E, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE,
               hz.PCWrPendingF, hz.PCSrcW};
        checks++;
        if (act !== x.outs) begin
          errors++;
          $display("FAIL outputs cyc=%0d rst_n=%0b got=%b want=%b (1EM 1EW 2EM 2EW 12DE RWM RWW MTRE PCWP PCSW)",
                   x.cyc, rst_n, act, x.outs);
        end
`ifdef HAZARD_TRK_PERF_EN
        checks++;
        if (int'(stall_count) != x.stall_cnt || int'(flush_count) != x.flush_cnt) begin
          errors++;
          $display("FAIL perf_counters cyc=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   x.cyc, stall_count, flush_count, x.stall_cnt, x.flush_cnt);
        end
`endif
      end
    end
  end

  initial begin
    cur = '{fv:0, rw:0, ld:0, br:0, cond:0, stall:0, fd:0, fe:0, ra1:0, ra2:0, wa3:0};
    model_clear();
    apply_stim();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_expect();

    for (int i = 0; i < NCYC; i++) begin
      one_cycle(1'b0);
      // Asynchronous reset in the middle of traffic, held for a few cycles.
      if (i == RST_AT) begin
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (hz.PCWrPendingF !== 1'b0 || hz.Match_1E_M !== 1'b0 || hz.RegWriteM !== 1'b0 ||
            hz.RegWriteW !== 1'b0 || hz.PCSrcW !== 1'b0 || hz.MemtoRegE !== 1'b0) begin
          errors++;
          $display("FAIL async_reset got pcwp=%0b rwm=%0b rww=%0b pcsw=%0b want all 0",
                   hz.PCWrPendingF, hz.RegWriteM, hz.RegWriteW, hz.PCSrcW);
        end
        // Expectation already queued for this cycle predates the reset; replace it.
        void'(exp_q.pop_back());
        push_expect();
      end
      if (i == RST_AT + 3) begin
        #1 rst_n = 1'b1;
      end
    end

`ifdef HAZARD_TRK_PERF_EN
    for (int i = 0; i < (1 << CNTW) + 5; i++) one_cycle(1'b1);
    checks++;
    if (m_stall_cnt != CMAX) begin
      errors++;
      $display("FAIL stall_saturation model=%0d want=%0d", m_stall_cnt, CMAX);
    end
`endif

    // Let the monitor drain; an undrained queue is a failure, not a hang.
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
